// File: rtl/sc_pkg.sv
// ============================================================================
// Module : sc_pkg
// Brief  : Shared stochastic-computing types and early-termination helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sc_pkg;

  localparam int c_et_w = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } et_state_t;

  // {hi, lo}: hi once the count has reached thresh, lo once even all-ones in the
  // remaining samples cannot reach it. Wide operands keep the sum overflow-free.
  function automatic logic [1:0] et_resolved(
    input logic [c_et_w-1:0] count,
    input logic [c_et_w-1:0] cycles,
    input logic [c_et_w-1:0] thresh,
    input logic [c_et_w-1:0] len
  );
    logic hi;
    logic lo;
    hi = (count >= thresh);
    lo = ((count + (len - cycles)) < thresh);
    return {hi, lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_et_check.sv
// ============================================================================
// Module : sc_et_check
// Brief  : Combinational hi/lo evaluator for threshold early termination.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sc_et_check
  import sc_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int STREAM_LEN = 255
) (
  input  logic [CNT_W:0]   nc,
  input  logic [CNT_W:0]   ny,
  input  logic [CNT_W-1:0] thresh,
  output logic             hi,
  output logic             lo
);

  logic [1:0] w_res;

  assign w_res = et_resolved(c_et_w'(nc), c_et_w'(ny), c_et_w'(thresh),
                             c_et_w'(STREAM_LEN));
  assign hi = w_res[1];
  assign lo = w_res[0];

endmodule

`default_nettype wire

// File: rtl/sc_et_accum.sv
// ============================================================================
// Module : sc_et_accum
// Brief  : Stochastic bitstream counter with threshold early termination.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sc_et_accum
  import sc_pkg::*;
#(
  parameter int  STREAM_LEN = 255,
  parameter bit  ET_EN      = 1'b1,
  localparam int CNT_W      = $clog2(STREAM_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             x_in,
  input  logic [CNT_W-1:0] thresh,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             decision,
  output logic             early,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W:0] c_len = (CNT_W + 1)'(STREAM_LEN);

  et_state_t        r_state;
  et_state_t        w_state_next;
  logic [CNT_W-1:0] r_thresh;
  logic [CNT_W:0]   w_nc;
  logic [CNT_W:0]   w_ny;
  logic             w_hi;
  logic             w_lo;
  logic             w_at_len;
  logic             w_end;
  logic             w_accept;

  assign w_nc     = {1'b0, count} + {{CNT_W{1'b0}}, x_in};
  assign w_ny     = {1'b0, cycles} + {{CNT_W{1'b0}}, 1'b1};
  assign w_at_len = (w_ny == c_len);
  assign w_end    = w_at_len | (ET_EN & (w_hi | w_lo));
  assign w_accept = start & ((r_state == IDLE) | (r_state == DONE));

  sc_et_check #(
    .CNT_W      (CNT_W),
    .STREAM_LEN (STREAM_LEN)
  ) u_check (
    .nc     (w_nc),
    .ny     (w_ny),
    .thresh (r_thresh),
    .hi     (w_hi),
    .lo     (w_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_end) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Results hold after DONE and are only cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thresh <= '0;
      count    <= '0;
      cycles   <= '0;
      decision <= 1'b0;
      early    <= 1'b0;
    end else if (w_accept) begin
      r_thresh <= thresh;
      count    <= '0;
      cycles   <= '0;
      decision <= 1'b0;
      early    <= 1'b0;
    end else if (r_state == RUN) begin
      count  <= w_nc[CNT_W-1:0];
      cycles <= w_ny[CNT_W-1:0];
      if (w_end) begin
        decision <= w_hi;
        early    <= ~w_at_len;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sc_et_accum.sv
// ============================================================================
// Module : tb_sc_et_accum
// Brief  : Bench for sc_et_accum, full-length (index 0) and early-terminating
//          (index 1) instances driven in parallel.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sc_et_accum;

  localparam int LEN    = 255;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       x_in   = 1'b0;
  logic [7:0] thresh = 8'd0;

  logic [1:0] busy_v;
  logic [1:0] done_v;
  logic [1:0] dec_v;
  logic [1:0] early_v;
  logic [7:0] count_v  [2];
  logic [7:0] cycles_v [2];

  int n_assert = 0;
  int n_fail   = 0;
  int mode     = 0;
  logic [7:0] lfsr = 8'd1;

  always #5 clk = ~clk;

  sc_et_accum #(.STREAM_LEN(LEN), .ET_EN(1'b0)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .thresh(thresh),
    .busy(busy_v[0]), .done(done_v[0]), .count(count_v[0]),
    .decision(dec_v[0]), .early(early_v[0]), .cycles(cycles_v[0])
  );

  sc_et_accum #(.STREAM_LEN(LEN), .ET_EN(1'b1)) u_dut_et (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .thresh(thresh),
    .busy(busy_v[1]), .done(done_v[1]), .count(count_v[1]),
    .decision(dec_v[1]), .early(early_v[1]), .cycles(cycles_v[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus bit source: constant 0, constant 1, or an 8-bit maximal LFSR
  // (poly 0x1D) compared against 128.
  initial forever begin
    @(posedge clk);
    #1;
    case (mode)
      0: x_in = 1'b0;
      1: x_in = 1'b1;
      default: begin
        x_in = (lfsr < 8'd128);
        lfsr = lfsr[7] ? ((lfsr << 1) ^ 8'h1D) : (lfsr << 1);
      end
    endcase
  end

  // Reference model: tallies ones and decides as soon as the outcome is fixed.
  int m_ph    [2];
  int m_cnt   [2];
  int m_k     [2];
  int m_th    [2];
  int m_dec   [2];
  int m_early [2];

  initial begin
    for (int e = 0; e < 2; e++) begin
      m_ph[e] = P_IDLE; m_cnt[e] = 0; m_k[e] = 0;
      m_th[e] = 0; m_dec[e] = 0; m_early[e] = 0;
    end
    forever begin
      @(negedge clk);
      for (int e = 0; e < 2; e++) begin
        if (!rst_n) begin
          m_ph[e] = P_IDLE; m_cnt[e] = 0; m_k[e] = 0;
          m_th[e] = 0; m_dec[e] = 0; m_early[e] = 0;
        end
        check($sformatf("busy[%0d]", e), int'(busy_v[e]), int'(m_ph[e] == P_RUN));
        check($sformatf("done[%0d]", e), int'(done_v[e]), int'(m_ph[e] == P_DONE));
        check($sformatf("count[%0d]", e), int'(count_v[e]), m_cnt[e]);
        check($sformatf("cycles[%0d]", e), int'(cycles_v[e]), m_k[e]);
        check($sformatf("decision[%0d]", e), int'(dec_v[e]), m_dec[e]);
        check($sformatf("early[%0d]", e), int'(early_v[e]), m_early[e]);
      end
      if (rst_n) begin
        for (int e = 0; e < 2; e++) begin
          if (m_ph[e] == P_RUN) begin
            m_k[e]   = m_k[e] + 1;
            m_cnt[e] = m_cnt[e] + int'(x_in);
            if (m_k[e] == LEN ||
                (e == 1 && (m_cnt[e] >= m_th[e] || m_cnt[e] + (LEN - m_k[e]) < m_th[e]))) begin
              m_ph[e]    = P_DONE;
              m_dec[e]   = int'(m_cnt[e] >= m_th[e]);
              m_early[e] = int'(m_k[e] != LEN);
            end
          end else if (start) begin
            m_ph[e] = P_RUN; m_th[e] = int'(thresh);
            m_cnt[e] = 0; m_k[e] = 0; m_dec[e] = 0; m_early[e] = 0;
          end else begin
            m_ph[e] = P_IDLE;
          end
        end
      end
    end
  end

  task automatic start_run(input int th, input int md);
    @(posedge clk);
    #1;
    thresh = 8'(th);
    mode   = md;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int e);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_v[e]) return;
    end
    check($sformatf("done_timeout[%0d]", e), 0, 1);
  endtask

  task automatic expect_res(input int e, input int cnt, input int cyc,
                            input int dec, input int erl);
    check($sformatf("lit_count[%0d]", e), int'(count_v[e]), cnt);
    check($sformatf("lit_cycles[%0d]", e), int'(cycles_v[e]), cyc);
    check($sformatf("lit_decision[%0d]", e), int'(dec_v[e]), dec);
    check($sformatf("lit_early[%0d]", e), int'(early_v[e]), erl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      check($sformatf("rst_busy[%0d]", e), int'(busy_v[e]), 0);
      check($sformatf("rst_done[%0d]", e), int'(done_v[e]), 0);
      expect_res(e, 0, 0, 0, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ones with thresh 10: early hi after 10 samples; full run counts all 255.
    start_run(10, 1);
    wait_done(1);
    expect_res(1, 10, 10, 1, 1);
    wait_done(0);
    expect_res(0, 255, 255, 1, 0);

    // Zeros with thresh 10: lo fires once only 9 samples remain.
    start_run(10, 0);
    wait_done(1);
    expect_res(1, 0, 246, 0, 1);
    wait_done(0);
    expect_res(0, 0, 255, 0, 0);

    // One LFSR period against B=128 yields exactly 127 ones.
    start_run(128, 2);
    wait_done(0);
    expect_res(0, 127, 255, 0, 0);

    // Reset after 5 samples aborts the run with no done.
    start_run(100, 1);
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_cycles", int'(cycles_v[1]), 5);
    rst_n = 1'b0;
    #1;
    for (int e = 0; e < 2; e++) begin
      check($sformatf("abort_busy[%0d]", e), int'(busy_v[e]), 0);
      check($sformatf("abort_done[%0d]", e), int'(done_v[e]), 0);
      expect_res(e, 0, 0, 0, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_run(3, 1);
    wait_done(1);
    expect_res(1, 3, 3, 1, 1);
    wait_done(0);
    expect_res(0, 255, 255, 1, 0);

    // start held through RUN; thresh changed mid-run; restart from DONE with thresh 0.
    @(posedge clk);
    #1;
    thresh = 8'd5;
    mode   = 1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    thresh = 8'd0;
    wait_done(1);
    expect_res(1, 5, 5, 1, 1);
    @(posedge clk);
    #1;
    check("restart_busy", int'(busy_v[1]), 1);
    check("restart_cycles", int'(cycles_v[1]), 0);
    check("restart_count", int'(count_v[1]), 0);
    wait_done(1);
    expect_res(1, 1, 1, 1, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0);
    expect_res(0, 255, 255, 1, 0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
